component_delay_elastic: RTL

Parametrised successor to the fixed register delay line.
- A CYCLES-deep pipeline of WIDTH-bit stages, each stage carrying its own valid bit.
- valid/ready handshakes on both sides, backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between datapath components whose latency must be matched but whose consumer can stall.

---
 rtl/component_delay_elastic.sv | 103 ++++++++++
 1 files changed

// File: rtl/component_delay_elastic.sv
// Elastic CYCLES-deep delay line: per-stage valid bits, valid/ready handshakes, bubble collapse,
// synchronous flush and registered occupancy. Optional macro COMPONENT_DELAY_ELASTIC_CLEAR_DATA_EN.
module component_delay_elastic #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CYCLES = 4,
  parameter int unsigned CNT_W  = $clog2(CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  logic [CYCLES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [CYCLES];
  logic [CNT_W-1:0]  r_occ;

  logic [CYCLES:0]   w_ready;
  logic [CYCLES-1:0] w_prev_valid;
  logic [WIDTH-1:0]  w_prev_data [CYCLES];
  logic              w_in_xfer;
  logic              w_out_xfer;

  // Ready ripples back from the output: an empty stage always accepts, closing bubbles.
  always_comb begin
    w_ready[CYCLES] = out_ready;
    for (int i = int'(CYCLES) - 1; i >= 0; i--) begin
      w_ready[i] = !r_valid[i] || w_ready[i+1];
    end
  end

  assign in_ready   = w_ready[0] && !flush;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_prev_valid[0] = w_in_xfer;
    w_prev_data[0]  = data_in;
    for (int i = 1; i < int'(CYCLES); i++) begin
      w_prev_valid[i] = r_valid[i-1];
      w_prev_data[i]  = r_data[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < int'(CYCLES); i++) begin
        if (w_ready[i]) r_valid[i] <= w_prev_valid[i];
      end
    end
  end

`ifdef COMPONENT_DELAY_ELASTIC_CLEAR_DATA_EN
  // Bubbles carry zero data so data_out reads 0 whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CYCLES); i++) r_data[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(CYCLES); i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < int'(CYCLES); i++) begin
        if (w_ready[i]) r_data[i] <= w_prev_valid[i] ? w_prev_data[i] : '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(CYCLES); i++) begin
      if (w_ready[i]) r_data[i] <= w_prev_data[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
    end
  end

  assign out_valid = r_valid[CYCLES-1];
  assign data_out  = r_data[CYCLES-1];
  assign occupancy = r_occ;

  a_occ_popcount : assert property (@(posedge clk) disable iff (rst)
    int'(r_occ) == $countones(r_valid));
  a_occ_bound : assert property (@(posedge clk) disable iff (rst)
    int'(r_occ) <= int'(CYCLES));

endmodule
